ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the write direction of the keyboard link whose receive side is key_detect.
- Sends one command byte per request to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the standard request-to-send sequence: inhibit clock, start bit, 8 data bits LSB first, odd parity, stop, device ack.
- Drives the open-drain PS2Clk/PS2Data lines through output-enables; the top level builds the tri-states.
- Flags key_detect to ignore line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2Clk is held low before the start bit (100 us at 100 MHz); minimum 2.
- TIMEOUT_CYCLES, 1500000, clk cycles from end of inhibit to end of ack before abort (15 ms); minimum 64.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte to send
- tx_valid  in  1  request; accepted when tx_ready=1
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS2Clk pin level (asynchronous)
- ps2_data_in  in  1  raw PS2Data pin level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2Clk low, 0 = release
- ps2_data_oe  out  1  1 = pull PS2Data low, 0 = release
- busy  out  1  high in every state except IDLE
- rx_inhibit  out  1  equals busy; gates key_detect
- done  out  1  one-cycle pulse: byte sent and acked
- ack_err  out  1  one-cycle pulse: no ack, or timeout

Behaviour:
- Reset (asynchronous, while reset=0): state IDLE; tx_ready=1; ps2_clk_oe=ps2_data_oe=busy=rx_inhibit=done=ack_err=0; counters and shift register cleared. An asserted reset mid-transfer releases both lines immediately.
- Input conditioning: ps2_clk_in and ps2_data_in each pass a 2-FF synchronizer. fall = sync_clk was 1 last cycle and is 0 this cycle.
- IDLE:
  - tx_valid&tx_ready latches frame = {1'b1 stop, ~^tx_data odd parity, tx_data}.
  - Next cycle goes to INHIBIT. tx_valid while not IDLE is ignored.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe rises to 1 in the final cycle.
  - Then goes to REQ.
- REQ (1 cycle): ps2_clk_oe=0, ps2_data_oe=1 (start bit), timeout counter cleared. Then goes to SHIFT with bit index 0.
- SHIFT:
  - Each fall drives frame[idx] (data_oe = ~frame[idx]) and increments idx; bits 0-9 go out on falls 1-10.
  - data_oe holds between falls.
  - After the fall that drives idx 9 (stop, released), goes to ACK.
- ACK:
  - On the next fall, sample sync_data: 0 marks ack good, 1 marks ack bad.
  - Then goes to WAIT_IDLE.
- WAIT_IDLE:
  - Waits until sync_clk=1 and sync_data=1 in the same cycle.
  - Then pulses done (ack good) or ack_err (ack bad) and returns to IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1, both oe are released, ack_err pulses, and the state returns to IDLE.
  - If a fall or idle condition coincides with the timeout cycle, the timeout wins.
- done and ack_err are mutually exclusive. tx_ready returns to 1 in the cycle after the pulse.
- Counter widths: $clog2(INHIBIT_CYCLES) and $clog2(TIMEOUT_CYCLES); counters saturate, never wrap.
- Falls seen in IDLE, INHIBIT or REQ are ignored. The inhibit pulls clk low itself, so that edge is not counted.

Decomposition:
- ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  - command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE
  - the key scan codes also used by display_top
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for clk/data; reusable by key_detect.

Test Plan:
- Bench parameters for all scenarios: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000. Device model clocks at 40-cycle half-period and samples data on rising edges.
1. Send 0x01 -> clk_oe high 8 cycles; device captures start 0, data bits 1,0,0,0,0,0,0,0, parity 0, stop 1. Model acks -> done pulses once, ack_err 0, tx_ready back to 1.
2. Send 0xED -> captured bits 1,0,1,1,0,1,1,1, parity 1. Model acks -> done=1.
3. Send 0xFF, model never pulls data low on the 11th clock -> ack_err pulses once, done 0.
4. Send 0xEE, model stops clocking after 4 bits -> ack_err at exactly 2000 cycles after REQ; both oe 0 afterwards.
5. tx_valid held high through a whole transfer with tx_data changed mid-frame -> only the first byte is transmitted. A second transfer starts the cycle after tx_ready returns to 1.
6. reset=0 asserted in the middle of SHIFT -> ps2_clk_oe, ps2_data_oe and busy drop within the same cycle. After release, a new 0x01 transfer completes with done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and
// the scan codes the display logic decodes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  localparam logic [7:0] KEY_W       = 8'h1D;
  localparam logic [7:0] KEY_A       = 8'h1C;
  localparam logic [7:0] KEY_S       = 8'h1B;
  localparam logic [7:0] KEY_D       = 8'h23;
  localparam logic [7:0] KEY_SPACE   = 8'h29;
  localparam logic [7:0] KEY_ENTER   = 8'h5A;
  localparam logic [7:0] KEY_EXT     = 8'hE0;
  localparam logic [7:0] KEY_BREAK   = 8'hF0;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the asynchronous PS2Clk/PS2Data pins into the clk domain and flags
// falling edges of the synchronized clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_sync_clk,
  output logic o_sync_data,
  output logic o_clk_fall
);

  logic [1:0] r_clk_ff;
  logic [1:0] r_data_ff;
  logic       r_clk_prev;

  // Two-stage synchronizers; reset to the idle-high bus level so reset
  // release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_ff   <= 2'b11;
      r_data_ff  <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_ff   <= {r_clk_ff[0], i_clk_raw};
      r_data_ff  <= {r_data_ff[0], i_data_raw};
      r_clk_prev <= r_clk_ff[1];
    end
  end

  assign o_sync_clk  = r_clk_ff[1];
  assign o_sync_data = r_data_ff[1];
  assign o_clk_fall  = r_clk_prev & ~r_clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Runs the request-to-send sequence
// (clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, device
// ack) through open-drain output enables, with an overall timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a command byte, both lines released
// INHIBIT   | holding PS2Clk low; PS2Data pulled low in the last cycle
// REQ       | PS2Clk released, start bit on PS2Data, timeout cleared
// SHIFT     | device clocks: each fall drives the next frame bit
// ACK       | stop bit out; next fall samples the device ack
// WAIT_IDLE | waiting for both lines high before reporting the result
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_STOP = 4'd9;

  ps2_tx_state_e r_state;
  ps2_tx_state_e w_next_state;

  logic [9:0]    r_frame;
  logic [3:0]    r_idx;
  logic          r_data_oe;
  logic          r_ack_bad;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;

  logic w_sync_clk;
  logic w_sync_data;
  logic w_clk_fall;
  logic w_timed;
  logic w_timeout;
  logic w_tx_ready;
  logic w_clk_oe;
  logic w_data_oe;
  logic w_done;
  logic w_ack_err;

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst_n       (reset),
    .i_clk_raw   (ps2_clk_in),
    .i_data_raw  (ps2_data_in),
    .o_sync_clk  (w_sync_clk),
    .o_sync_data (w_sync_data),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_timed   = (r_state == SHIFT) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_timeout = w_timed && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and outputs; a timeout overrides any coincident fall or idle.
  always_comb begin
    w_next_state = r_state;
    w_tx_ready   = 1'b0;
    w_clk_oe     = 1'b0;
    w_data_oe    = 1'b0;
    w_done       = 1'b0;
    w_ack_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_ready = 1'b1;
        if (tx_valid) w_next_state = INHIBIT;
      end
      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_inh_cnt == '0) begin
          w_data_oe    = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_data_oe    = 1'b1;
        w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_timeout) begin
          w_ack_err    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_data_oe = r_data_oe;
          if (w_clk_fall && (r_idx == IDX_STOP)) w_next_state = ACK;
        end
      end
      ACK: begin
        if (w_timeout) begin
          w_ack_err    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_data_oe = r_data_oe;
          if (w_clk_fall) w_next_state = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_timeout) begin
          w_ack_err    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_data_oe = r_data_oe;
          if (w_sync_clk && w_sync_data) begin
            w_done       = ~r_ack_bad;
            w_ack_err    = r_ack_bad;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Frame latch, inhibit down-counter, timeout counter, bit shifter, ack flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame   <= '0;
      r_idx     <= '0;
      r_data_oe <= 1'b0;
      r_ack_bad <= 1'b0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_frame   <= {1'b1, odd_parity(tx_data), tx_data};
            r_inh_cnt <= INH_LOAD;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt != '0) r_inh_cnt <= r_inh_cnt - IW'(1);
        end
        REQ: begin
          r_to_cnt  <= '0;
          r_idx     <= '0;
          r_data_oe <= 1'b1;
          r_ack_bad <= 1'b0;
        end
        SHIFT, ACK, WAIT_IDLE: begin
          if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + TW'(1);
          if (w_timeout) begin
            r_data_oe <= 1'b0;
          end else if (w_clk_fall) begin
            if (r_state == SHIFT) begin
              r_data_oe <= ~r_frame[r_idx];
              r_idx     <= r_idx + 4'd1;
            end else if (r_state == ACK) begin
              r_ack_bad <= w_sync_data;
            end
          end
        end
        default: r_data_oe <= 1'b0;
      endcase
    end
  end

  assign tx_ready    = w_tx_ready;
  assign ps2_clk_oe  = w_clk_oe;
  assign ps2_data_oe = w_data_oe;
  assign busy        = (r_state != IDLE);
  assign rx_inhibit  = busy;
  assign done        = w_done;
  assign ack_err     = w_ack_err;

endmodule
